// File: rtl/smc_pkg.sv
// Shared types and constants for the transistor sequencing controller.
// Holds the FSM state type, job sizing and the output weights.
package smc_pkg;

    localparam int NUM_TX = 6;
    localparam int VAL_W  = 10;

    localparam int OUT_WA = 3;
    localparam int OUT_WB = 4;
    localparam int OUT_WC = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EVAL = 3'd2,
        ST_SUM  = 3'd3,
        ST_OUT  = 3'd4
    } smc_state_e;

    typedef struct packed {
        logic [2:0] w;
        logic [2:0] vgs;
        logic [2:0] vds;
    } smc_beat_t;

endpackage

// File: rtl/smc_eval.sv
// Combinational square-law evaluator for one transistor.
// Produces Id or gm (selected by id_sel), floored after divide by 3.
module smc_eval #(
    parameter int VAL_W = 10
) (
    input  logic [2:0]       w,
    input  logic [2:0]       v_gs,
    input  logic [2:0]       v_ds,
    input  logic             id_sel,
    output logic [VAL_W-1:0] value
);

    logic [9:0] w_e;
    logic [9:0] ds_e;
    logic [9:0] ov_e;
    logic [9:0] num;
    logic [9:0] quo;

    assign w_e  = {7'd0, w};
    assign ds_e = {7'd0, v_ds};
    assign ov_e = {7'd0, v_gs} - 10'd1;

    // Full-precision numerator per operating region, then divide.
    always_comb begin
        num = '0;
        if (v_gs <= 3'd1) begin
            num = '0;
        end else if (ov_e > ds_e) begin
            if (id_sel)
                num = w_e * ds_e * ((ov_e << 1) - ds_e);
            else
                num = (w_e * ds_e) << 1;
        end else begin
            if (id_sel)
                num = w_e * ov_e * ov_e;
            else
                num = (w_e * ov_e) << 1;
        end
        quo   = num / 10'd3;
        value = VAL_W'(quo);
    end

endmodule

// File: rtl/smc_seq_ctrl.sv
// Collects six transistor beats, ranks their values one per cycle
// through a shared evaluator, and emits a weighted sum of three.
module smc_seq_ctrl #(
    parameter int NUM_TX = 6,
    parameter int VAL_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_n,
    output logic             busy
);

    import smc_pkg::*;

    smc_state_e       state;
    logic [2:0]       cnt;
    logic [1:0]       mode_q;
    smc_beat_t        slots  [NUM_TX];
    logic [VAL_W-1:0] sorted [NUM_TX];
    logic [VAL_W-1:0] ins    [NUM_TX];
    logic [VAL_W-1:0] ev;
    logic [VAL_W-1:0] out_q;
    logic [VAL_W+2:0] sum;
    smc_beat_t        beat;
    smc_beat_t        cur;

    assign beat      = '{w: W, vgs: V_GS, vds: V_DS};
    assign cur       = slots[cnt];
    assign in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);
    assign out_n     = out_q;

    smc_eval #(.VAL_W(VAL_W)) u_eval (
        .w      (cur.w),
        .v_gs   (cur.vgs),
        .v_ds   (cur.vds),
        .id_sel (mode_q[0]),
        .value  (ev)
    );

    // Insert the evaluated value into the descending list.
    always_comb begin
        ins[0] = (sorted[0] >= ev) ? sorted[0] : ev;
        for (int i = 1; i < NUM_TX; i++) begin
            if (sorted[i] >= ev)
                ins[i] = sorted[i];
            else if (sorted[i-1] < ev)
                ins[i] = sorted[i-1];
            else
                ins[i] = ev;
        end
    end

    // Weighted sum of the top or bottom three ranked values.
    always_comb begin
        logic [VAL_W+2:0] a, b, c;
        if (mode_q[1]) begin
            a = (VAL_W+3)'(sorted[0]);
            b = (VAL_W+3)'(sorted[1]);
            c = (VAL_W+3)'(sorted[2]);
        end else begin
            a = (VAL_W+3)'(sorted[3]);
            b = (VAL_W+3)'(sorted[4]);
            c = (VAL_W+3)'(sorted[5]);
        end
        if (mode_q[0])
            sum = (VAL_W+3)'(OUT_WA) * a
                + (VAL_W+3)'(OUT_WB) * b
                + (VAL_W+3)'(OUT_WC) * c;
        else
            sum = a + b + c;
    end

    // Job sequencing: load, evaluate, sum, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= '0;
            out_q  <= '0;
            for (int i = 0; i < NUM_TX; i++) begin
                sorted[i] <= '0;
                slots[i]  <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE: if (in_valid) begin
                    slots[0] <= beat;
                    cnt      <= 3'd1;
                    mode_q   <= mode;
                    state    <= ST_LOAD;
                    for (int i = 0; i < NUM_TX; i++)
                        sorted[i] <= '0;
                end
                ST_LOAD: if (in_valid) begin
                    slots[cnt] <= beat;
                    if (cnt == 3'(NUM_TX - 1)) begin
                        cnt   <= '0;
                        state <= ST_EVAL;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_EVAL: begin
                    sorted <= ins;
                    if (cnt == 3'(NUM_TX - 1)) begin
                        cnt   <= '0;
                        state <= ST_SUM;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_SUM: begin
                    out_q <= VAL_W'(sum);
                    state <= ST_OUT;
                end
                ST_OUT: if (out_ready)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Randomised bench for smc_seq_ctrl against a behavioural job model.
// Covers fixed jobs, gaps, back-pressure, aborts and reset.
module tb_smc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [2:0] W, V_GS, V_DS;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_n;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bw[6], bg[6], bd[6];

    smc_seq_ctrl #(.NUM_TX(6), .VAL_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tx_val(int w, int g, int d, bit id);
        int v;
        if (g <= 1) return 0;
        v = g - 1;
        if (v > d)
            return id ? (w * d * (2 * v - d)) / 3 : (2 * w * d) / 3;
        return id ? (w * v * v) / 3 : (2 * w * v) / 3;
    endfunction

    function automatic int model(logic [1:0] m);
        int q[$];
        int s;
        for (int i = 0; i < 6; i++)
            q.push_back(tx_val(bw[i], bg[i], bd[i], m[0]));
        q.rsort();
        s = m[1] ? 0 : 3;
        if (m[0])
            return 3 * q[s] + 4 * q[s+1] + 5 * q[s+2];
        return q[s] + q[s+1] + q[s+2];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(int w, int g, int d);
        for (int i = 0; i < 6; i++) begin
            bw[i] = w; bg[i] = g; bd[i] = d;
        end
    endtask

    task automatic run_job(input logic [1:0] m, input int gap,
                           input int hold, input bit rst_out,
                           input string nm);
        int exp, k, t_last, wt;
        bit rdy, acc;
        exp = model(m);
        k = 0;
        t_last = 0;
        while (k < 6) begin
            in_valid = ($urandom_range(99) >= gap);
            mode = (k == 0) ? m : 2'($urandom);
            W    = 3'(bw[k]);
            V_GS = 3'(bg[k]);
            V_DS = 3'(bd[k]);
            rdy = in_ready;
            acc = in_valid && rdy;
            step();
            if (acc) begin
                k++;
                t_last = cyc;
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_after_last: rdy=%b busy=%b need 0/1",
                     nm, in_ready, busy);
        end
        wt = 0;
        while (!out_valid && wt < 20) begin
            step();
            wt++;
        end
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid never rose", nm);
        end else begin
            n_chk++;
            if (cyc - t_last !== 7) begin
                n_fail++;
                $display("FAIL %s latency: got %0d edges need 7",
                         nm, cyc - t_last);
            end
        end
        n_chk++;
        if (out_n !== 10'(exp)) begin
            n_fail++;
            $display("FAIL %s out_n: got %0d need %0d", nm, out_n, exp);
        end
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            n_chk++;
            if (out_valid !== 1'b1 || out_n !== 10'(exp)) begin
                n_fail++;
                $display("FAIL %s hold%0d: v=%b n=%0d need 1/%0d",
                         nm, i, out_valid, out_n, exp);
            end
        end
        if (rst_out) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            n_chk++;
            if (out_valid !== 1'b0 || out_n !== 10'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s rst_in_out: v=%b n=%0d b=%b need 0/0/0",
                         nm, out_valid, out_n, busy);
            end
        end else begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n_chk++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s release: v=%b b=%b r=%b need 0/0/1",
                         nm, out_valid, busy, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        mode = 2'b11;
        W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
        step();
        step();
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_n !== 10'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: r=%b v=%b n=%0d b=%b need 1/0/0/0",
                     in_ready, out_valid, out_n, busy);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        step();
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: b=%b r=%b need 0/1",
                     busy, in_ready);
        end
    endtask

    task automatic test_fixed();
        fill(1, 3, 1);
        run_job(2'b01, 0, 0, 0, "triode_id");
        run_job(2'b00, 0, 0, 0, "triode_gm");
        fill(7, 7, 7);
        run_job(2'b11, 0, 0, 0, "max_id");
        for (int i = 0; i < 6; i++) begin
            bw[i] = i + 1; bg[i] = 4; bd[i] = 7;
        end
        run_job(2'b10, 0, 0, 0, "ramp_gm_hi");
        run_job(2'b00, 0, 0, 0, "ramp_gm_lo");
    endtask

    task automatic test_gaps_backpressure();
        for (int i = 0; i < 6; i++) begin
            bw[i] = i + 1; bg[i] = 4; bd[i] = 7;
        end
        run_job(2'b10, 50, 5, 0, "gaps_hold");
    endtask

    task automatic test_abort();
        int k;
        k = 0;
        mode = 2'b01;
        while (k < 3) begin
            in_valid = 1'b1;
            W = 3'd7; V_GS = 3'd7; V_DS = 3'd2;
            step();
            k++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: b=%b r=%b v=%b need 0/1/0",
                     busy, in_ready, out_valid);
        end
        fill(3, 4, 5);
        run_job(2'b11, 0, 0, 0, "after_abort");
    endtask

    task automatic test_cutoff();
        for (int i = 0; i < 6; i++) begin
            bw[i] = 7; bg[i] = i % 2; bd[i] = i;
        end
        run_job(2'b00, 0, 0, 0, "cutoff_gm");
        run_job(2'b11, 0, 0, 0, "cutoff_id");
    endtask

    task automatic test_rst_in_out();
        fill(5, 6, 2);
        run_job(2'b01, 0, 2, 1, "rst_in_out");
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 6; i++) begin
                bw[i] = $urandom_range(7);
                bg[i] = $urandom_range(7);
                bd[i] = $urandom_range(7);
            end
            run_job(2'($urandom), 30, $urandom_range(3), 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 6; i++) begin
                bw[i] = $urandom_range(7);
                bg[i] = $urandom_range(2, 7);
                bd[i] = $urandom_range(7);
            end
            run_job(2'($urandom), 0, 0, 0, "b2b");
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mode = '0;
        W = '0; V_GS = '0; V_DS = '0;
        #1;
        test_reset();
        test_fixed();
        test_gaps_backpressure();
        test_abort();
        test_cutoff();
        test_rst_in_out();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/smc_seq_ctrl.md
SMC_SEQ_CTRL -- requirements
Module: smc_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_TX, default 6, meaning transistor sets per job (fixed at 6 for this release).
REQ-002 SHALL have parameter VAL_W, default 10, meaning width of per-transistor values and of out_n.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a transistor beat is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-008 SHALL have port mode, input, 2 bits: bit0 1=Id/0=gm; bit1 1=largest three/0=smallest three.
REQ-009 SHALL have ports W, V_GS, V_DS, input, 3 bits each: one transistor's parameters.
REQ-010 SHALL have port out_valid, output, 1 bit: out_n holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_n, output, VAL_W bits: the weighted sum.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, EVAL, SUM, OUT.
REQ-015 SHALL accept a beat on any cycle with in_valid && in_ready; in_ready=1 only in IDLE and LOAD.
REQ-016 SHALL latch mode on the first accepted beat of a job (IDLE->LOAD) and ignore mode on later beats.
REQ-017 SHALL store beats in slots 0..5 in arrival order; gaps (in_valid=0) in LOAD are allowed and do not advance the slot count.
REQ-018 SHALL go LOAD->EVAL on the cycle after the 6th beat is accepted; in_ready=0 from that cycle.
REQ-019 SHALL, in EVAL, evaluate exactly one slot per cycle (slot i in EVAL cycle i, i=0..5) through a single shared evaluator and insert the result into a descending sorted register list of 6 entries.
REQ-020 SHALL compute value = 0 when V_GS<=1 (cutoff).
REQ-021 SHALL define triode as V_GS-1 > V_DS: Id=floor(W*V_DS*(2*(V_GS-1)-V_DS)/3), gm=floor(2*W*V_DS/3).
REQ-022 SHALL otherwise use saturation: Id=floor(W*(V_GS-1)^2/3), gm=floor(2*W*(V_GS-1)/3).
REQ-023 SHALL carry all intermediate products at full precision (>=9 bits) before the divide; no wrap-around is permitted.
REQ-024 SHALL, in SUM (one cycle), select n0..n2 (mode[1]=1) or n3..n5 (mode[1]=0), n0 largest; out_n = 3a+4b+5c for Id, a+b+c for gm; max value 1008 fits VAL_W.
REQ-025 SHALL register out_n and enter OUT with out_valid=1; last beat accepted in cycle t gives out_valid first in cycle t+8.
REQ-026 SHALL hold out_valid and out_n stable in OUT until out_ready=1, then go to IDLE next cycle with out_valid=0.
REQ-027 SHALL treat equal values in any order; ties do not change out_n.

Reset
REQ-028 SHALL, on rst=1 in any state (including mid-LOAD or OUT), go to IDLE next edge, discard partial jobs, and drive in_ready=1, out_valid=0, out_n=0, busy=0.
REQ-029 SHALL clear slot count and sorted list to 0 on reset; rst has priority over all handshakes in the same cycle.

Structure
REQ-030 SHALL place the state enum, NUM_TX, VAL_W and the output weights 3/4/5 in shared package smc_pkg.
REQ-031 SHALL instantiate one combinational sub-module smc_eval (W, V_GS, V_DS, id_sel -> value) exactly once.

Verification
REQ-032 SHALL cover: 6x(W=1,V_GS=3,V_DS=1), mode=01 -> out_n=12; mode=00 -> out_n=0.
REQ-033 SHALL cover: 6x(W=7,V_GS=7,V_DS=7), mode=11 -> out_n=1008 (max, no overflow).
REQ-034 SHALL cover: W=1..6, V_GS=4, V_DS=7, mode=10 -> out_n=30; mode=00 -> out_n=12.
REQ-035 SHALL cover: same job with random in_valid gaps and out_ready held low 5 cycles -> same out_n, out_valid held stable, out_valid at t+8 from last beat.
REQ-036 SHALL cover: rst asserted after 3 beats, then a fresh 6x(W=3,V_GS=4,V_DS=5) mode=11 job -> out_n=108, no residue from the aborted job.
REQ-037 SHALL cover: V_GS=0 and V_GS=1 beats -> value 0 (cutoff), checked with mode=00 -> out_n=0.
